// File: rtl/tx_ppm_pkg.sv
// Shared types and elaboration-time helpers for the PPM transmit modulator.
package tx_ppm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_GUARD = 2'd2
    } tx_state_e;

    // Number of data slots per frame (M).
    function automatic int unsigned ppm_slots(input int unsigned ppm_bits);
        return 32'(1) << ppm_bits;
    endfunction

    // Total frame length in clock cycles (F).
    function automatic int unsigned frame_cycles(input int unsigned ppm_bits,
                                                 input int unsigned slot_cycles,
                                                 input int unsigned guard_slots);
        return (ppm_slots(ppm_bits) + guard_slots) * slot_cycles;
    endfunction

    function automatic int unsigned cyc_width(input int unsigned slot_cycles);
        if (slot_cycles <= 32'd1) return 32'd1;
        return 32'($clog2(slot_cycles));
    endfunction

    // Slot counter must span both the data and the guard phase.
    function automatic int unsigned slot_width(input int unsigned ppm_bits,
                                               input int unsigned guard_slots);
        int unsigned n;
        n = (ppm_slots(ppm_bits) > guard_slots) ? ppm_slots(ppm_bits) : guard_slots;
        if (n <= 32'd1) return 32'd1;
        return 32'($clog2(n));
    endfunction

    function automatic bit params_ok(input int unsigned ppm_bits,
                                     input int unsigned slot_cycles,
                                     input int unsigned guard_slots,
                                     input int unsigned pulse_cycles,
                                     input int unsigned cnt_w);
        return (ppm_bits >= 32'd1) && (slot_cycles >= 32'd1) && (guard_slots >= 32'd1) &&
               (pulse_cycles >= 32'd1) && (pulse_cycles <= slot_cycles) && (cnt_w >= 32'd1);
    endfunction

endpackage

// File: rtl/tx_ppm_slot_timer.sv
// Cycle-within-slot and slot-within-phase counters for the PPM frame timer.
module tx_ppm_slot_timer
    import tx_ppm_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 4,
    parameter int unsigned SLOT_W      = 4
) (
    input  logic                         clk_sys,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic [SLOT_W-1:0]            slot_lim,
    output logic [cyc_width(SLOT_CYCLES)-1:0] cyc_idx,
    output logic [SLOT_W-1:0]            slot_idx,
    output logic                         cyc_last,
    output logic                         slot_last
);

    localparam int unsigned CYC_W = cyc_width(SLOT_CYCLES);

    assign cyc_last  = (cyc_idx == CYC_W'(SLOT_CYCLES - 1));
    assign slot_last = (slot_idx == slot_lim);

    // Both counters wrap to zero at the end of a phase, ready for the next one.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cyc_idx  <= '0;
            slot_idx <= '0;
        end else if (clr) begin
            cyc_idx  <= '0;
            slot_idx <= '0;
        end else if (en) begin
            if (cyc_last) begin
                cyc_idx  <= '0;
                slot_idx <= slot_last ? '0 : slot_idx + SLOT_W'(1);
            end else begin
                cyc_idx  <= cyc_idx + CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/tx_ppm_modulator.sv
// PPM transmit modulator: one laser pulse per accepted symbol, placed in the
// symbol's slot, followed by guard slots covering the far-end SPAD dead time.
module tx_ppm_modulator
    import tx_ppm_pkg::*;
#(
    parameter int unsigned PPM_BITS     = 4,
    parameter int unsigned SLOT_CYCLES  = 4,
    parameter int unsigned GUARD_SLOTS  = 4,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic                tx_en,
    input  logic [PPM_BITS-1:0] sym_data,
    input  logic                sym_valid,
    output logic                sym_ready,
    output logic                laser_pulse_out,
    output logic                frame_start,
    output logic                busy,
    output logic [CNT_W-1:0]    sym_cnt
);

    localparam int unsigned M      = ppm_slots(PPM_BITS);
    localparam int unsigned CYC_W  = cyc_width(SLOT_CYCLES);
    localparam int unsigned SLOT_W = slot_width(PPM_BITS, GUARD_SLOTS);

    if (!params_ok(PPM_BITS, SLOT_CYCLES, GUARD_SLOTS, PULSE_CYCLES, CNT_W)) begin : g_param_check
        $error("tx_ppm_modulator: illegal parameter combination");
    end

    tx_state_e           state_q, state_d;
    logic [PPM_BITS-1:0] sym_q, sym_d;
    logic                accept;
    logic                timer_clr, timer_en;
    logic [SLOT_W-1:0]   slot_lim;
    logic [CYC_W-1:0]    cyc_idx, nxt_cyc;
    logic [SLOT_W-1:0]   slot_idx, nxt_slot;
    logic                cyc_last, slot_last;
    logic                pulse_d;

    tx_ppm_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .SLOT_W      (SLOT_W)
    ) u_timer (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .clr       (timer_clr),
        .en        (timer_en),
        .slot_lim  (slot_lim),
        .cyc_idx   (cyc_idx),
        .slot_idx  (slot_idx),
        .cyc_last  (cyc_last),
        .slot_last (slot_last)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        sym_ready = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        slot_lim  = SLOT_W'(M - 1);
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sym_ready = tx_en && !rst;
                accept    = sym_valid && sym_ready;
                if (accept) begin
                    state_d   = ST_DATA;
                    timer_clr = 1'b1;
                end
            end
            ST_DATA: begin
                timer_en = 1'b1;
                if (cyc_last && slot_last) state_d = ST_GUARD;
            end
            ST_GUARD: begin
                slot_lim = SLOT_W'(GUARD_SLOTS - 1);
                timer_en = 1'b1;
                if (cyc_last && slot_last) begin
                    sym_ready = tx_en;
                    accept    = sym_valid && sym_ready;
                    if (accept) begin
                        state_d   = ST_DATA;
                        timer_clr = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Look one cycle ahead so the pulse can leave straight from a flop.
    always_comb begin
        nxt_cyc  = cyc_idx;
        nxt_slot = slot_idx;
        if (timer_clr) begin
            nxt_cyc  = '0;
            nxt_slot = '0;
        end else if (timer_en) begin
            if (cyc_last) begin
                nxt_cyc  = '0;
                nxt_slot = slot_last ? '0 : slot_idx + SLOT_W'(1);
            end else begin
                nxt_cyc  = cyc_idx + CYC_W'(1);
            end
        end
        sym_d   = accept ? sym_data : sym_q;
        pulse_d = (state_d == ST_DATA) && (nxt_slot == SLOT_W'(sym_d)) &&
                  (32'(nxt_cyc) < PULSE_CYCLES);
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            sym_q           <= '0;
            laser_pulse_out <= 1'b0;
            frame_start     <= 1'b0;
            busy            <= 1'b0;
            sym_cnt         <= '0;
        end else begin
            state_q         <= state_d;
            sym_q           <= sym_d;
            laser_pulse_out <= pulse_d;
            frame_start     <= accept;
            busy            <= (state_d != ST_IDLE);
            if (accept) sym_cnt <= sym_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/tx_ppm_modulator.md
# tx_ppm_modulator

Transmit-side counterpart to the SPAD receive front end: it converts a stream of data symbols into pulse-position-modulated (PPM) laser trigger pulses on `clk_sys`. Each accepted symbol selects one of 2^PPM_BITS time slots in a frame, followed by guard slots that cover SPAD dead time at the far end. The block sits between the symbol source (framer/FIFO, valid/ready) and the laser driver output pin.

## Interface
Parameters:
- `PPM_BITS`, 4: bits per symbol; M = 2^PPM_BITS data slots per frame.
- `SLOT_CYCLES`, 4: `clk_sys` cycles per slot; must be at least 1.
- `GUARD_SLOTS`, 4: idle slots after the data slots; must be at least 1.
- `PULSE_CYCLES`, 1: laser pulse width in cycles; must satisfy 1 <= PULSE_CYCLES <= SLOT_CYCLES.
- `CNT_W`, 16: width of the symbol counter.

Ports:
- `clk_sys` in 1: system clock; this is the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `tx_en` in 1: transmit enable.
- `sym_data` in PPM_BITS: symbol (slot index).
- `sym_valid` in 1: symbol available.
- `sym_ready` out 1: block accepts a symbol this cycle.
- `laser_pulse_out` out 1: registered laser trigger.
- `frame_start` out 1: one-cycle strobe in the first cycle of each frame.
- `busy` out 1: a frame is in progress.
- `sym_cnt` out CNT_W: count of transmitted symbols; wraps modulo 2^CNT_W.

## Operation
- Reset values: `sym_ready`=0, `laser_pulse_out`=0, `frame_start`=0, `busy`=0, `sym_cnt`=0, state IDLE.
- A symbol is accepted when `sym_valid` && `sym_ready` are both high in the same cycle. `sym_data` is latched on acceptance.
- States:
  - IDLE:
    - `sym_ready` = `tx_en`.
    - On accept, go to DATA with slot counter = 0 and cycle counter = 0 in the next cycle.
  - DATA:
    - The cycle counter runs 0..SLOT_CYCLES-1. The slot counter increments on cycle wrap.
    - After slot M-1 wraps, go to GUARD with the slot counter = 0.
  - GUARD:
    - Runs GUARD_SLOTS*SLOT_CYCLES cycles.
    - In its last cycle, `sym_ready` = `tx_en`.
    - On accept, go directly to DATA, giving back-to-back frames. Otherwise go to IDLE.
- Pulse rule: `laser_pulse_out` is high in DATA when slot counter == latched symbol and cycle counter < PULSE_CYCLES. It is produced from a register, not from a combinational compare.
- `sym_ready` is low in DATA and in every GUARD cycle except the last.
- `busy` is high in DATA and GUARD.
- `frame_start` is high in the first DATA cycle of each frame.
- `sym_cnt` increments by 1 on each accept.
- Deasserting `tx_en` mid-frame does not truncate the frame. It only blocks the next accept.
- With no symbol available at frame end, the block returns to IDLE. No pulse is emitted; no filler symbol is inserted.
- Reset asserted mid-frame or mid-pulse: all outputs drop immediately (asynchronous), and the latched symbol is discarded.

## Timing
- Accept at cycle t:
  - `frame_start` is high at t+1.
  - `laser_pulse_out` is high for cycles t+1+sym*SLOT_CYCLES through t+sym*SLOT_CYCLES+PULSE_CYCLES.
- Frame length F = (M+GUARD_SLOTS)*SLOT_CYCLES cycles. Back-to-back accepts are spaced exactly F cycles apart (t, t+F, ...).
- `busy` is high from t+1 to t+F inclusive when no further symbol follows.
- Counter widths:
  - Cycle counter: clog2(SLOT_CYCLES), minimum 1.
  - Slot counter: clog2(max(M, GUARD_SLOTS)).
  - Slot compare is exact-width against `sym_data`; no overflow is possible.
- Pulses never straddle slot boundaries, and at most one pulse occurs per frame.

## Structure
- Package `tx_ppm_pkg`:
  - state enum (IDLE, DATA, GUARD);
  - localparam helpers for M, F and counter widths;
  - parameter legality checks (SLOT_CYCLES>=1, GUARD_SLOTS>=1, PULSE_CYCLES range).
- Sub-module `tx_ppm_slot_timer`:
  - cycle and slot counters with load/clear inputs;
  - outputs `cyc_last`, `slot_last`, `slot_idx`, `cyc_idx`.
- The top level holds the FSM, symbol latch, output registers and `sym_cnt`.

## Test plan
All scenarios use the default parameters (M=16, SLOT_CYCLES=4, GUARD_SLOTS=4, PULSE_CYCLES=1, F=80) unless noted.
- Symbol 0 accepted at t -> `frame_start` and `laser_pulse_out` both high only at t+1; `busy` high for t+1..t+80; return to IDLE.
- Symbol 15 accepted at t -> single pulse at t+61; no other pulse in the frame.
- Symbols 3, 9, 0 with `sym_valid` held high -> accepts at t, t+80, t+160; pulses at t+13, t+117, t+161; `sym_cnt`=3.
- `tx_en`=0 with `sym_valid`=1 -> `sym_ready` stays 0 and no pulse. `tx_en` dropped at t+10 of a frame -> frame completes, then IDLE.
- PULSE_CYCLES=4, symbol 2 -> pulse on t+9..t+12. `rst` asserted at t+10 -> `laser_pulse_out`, `busy` and `sym_cnt` are 0 immediately, and the state is IDLE after release.
- CNT_W=4, 17 symbols sent -> `sym_cnt` wraps to 1; pulse timing unaffected.
